// File: rtl/lifo_stack_pkg.sv
// Shared constants for the parametrised LIFO stack: error codes and request decode.
package lifo_stack_pkg;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } op_e;

  function automatic op_e decode_op(input logic push, input logic pop);
    return op_e'({push, pop});
  endfunction

endpackage

// File: rtl/lifo_stack_mem.sv
// Register-array storage for the LIFO stack: one write port, one asynchronous read port.
module lifo_stack_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Out-of-range addresses only occur for non-power-of-two depths; read them as zero.
  always_comb begin
    rdata = '0;
    if (int'(raddr) < DEPTH) rdata = r_mem[raddr];
  end

endmodule

// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack with count, show-ahead top, replace-top and error reporting.
// Optional watermark outputs (almost_full, max_count) under LIFO_STACK_WATERMARK_EN.
module lifo_stack_param
  import lifo_stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
`ifdef LIFO_STACK_WATERMARK_EN
  parameter int AF_LEVEL = DEPTH - 1,
`endif
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [CW-1:0]    count,
  output logic             mem_full,
  output logic             mem_empty,
  output logic             error,
  output logic [1:0]       err_code
`ifdef LIFO_STACK_WATERMARK_EN
  ,
  output logic             almost_full,
  output logic [CW-1:0]    max_count
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [CW-1:0]    r_count;
  logic             r_error;
  logic [1:0]       r_err_code;
  logic             w_full;
  logic             w_empty;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [AW-1:0]    w_top_addr;
  logic [WIDTH-1:0] w_rdata;
  logic [CW-1:0]    w_count_nxt;
  logic             w_err_nxt;
  logic [1:0]       w_code_nxt;
  op_e              w_op;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_top_addr = AW'(r_count - CW'(1));
  assign w_op       = decode_op(push, pop);

  always_comb begin
    w_we        = 1'b0;
    w_waddr     = AW'(r_count);
    w_count_nxt = r_count;
    w_err_nxt   = 1'b0;
    w_code_nxt  = r_err_code;
    case (w_op)
      OP_PUSH: begin
        if (w_full) begin
          w_err_nxt  = 1'b1;
          w_code_nxt = ERR_OVF;
        end else begin
          w_we        = 1'b1;
          w_count_nxt = r_count + CW'(1);
          w_code_nxt  = ERR_NONE;
        end
      end
      OP_POP: begin
        if (w_empty) begin
          w_err_nxt  = 1'b1;
          w_code_nxt = ERR_UNF;
        end else begin
          w_count_nxt = r_count - CW'(1);
          w_code_nxt  = ERR_NONE;
        end
      end
      OP_REPL: begin
        if (w_empty) begin
          w_err_nxt  = 1'b1;
          w_code_nxt = ERR_UNF;
        end else begin
          w_we       = 1'b1;
          w_waddr    = w_top_addr;
          w_code_nxt = ERR_NONE;
        end
      end
      default: ;
    endcase
  end

`ifdef LIFO_STACK_WATERMARK_EN
  logic [CW-1:0] r_max;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
`ifdef LIFO_STACK_WATERMARK_EN
      r_max      <= '0;
`endif
    end else begin
      r_count    <= w_count_nxt;
      r_error    <= w_err_nxt;
      r_err_code <= w_code_nxt;
`ifdef LIFO_STACK_WATERMARK_EN
      if (w_count_nxt > r_max) r_max <= w_count_nxt;
`endif
    end
  end

  // Storage is not cleared by reset, but a request coinciding with reset must not write.
  lifo_stack_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clock(clock),
    .we   (w_we & reset_n),
    .waddr(w_waddr),
    .wdata(data_in),
    .raddr(w_top_addr),
    .rdata(w_rdata)
  );

  assign data_out  = w_empty ? '0 : w_rdata;
  assign count     = r_count;
  assign mem_full  = w_full;
  assign mem_empty = w_empty;
  assign error     = r_error;
  assign err_code  = r_err_code;

`ifdef LIFO_STACK_WATERMARK_EN
  assign almost_full = (int'(r_count) >= AF_LEVEL);
  assign max_count   = r_max;
`endif

endmodule

// File: tb/tb_lifo_stack_param.sv
// Self-checking bench for lifo_stack_param (WIDTH=8, DEPTH=8) against a queue-based model.
// Build with LIFO_STACK_WATERMARK_EN defined to also cover the watermark outputs.
module tb_lifo_stack_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic [CW-1:0]    count;
  logic             mem_full;
  logic             mem_empty;
  logic             error;
  logic [1:0]       err_code;
`ifdef LIFO_STACK_WATERMARK_EN
  logic             almost_full;
  logic [CW-1:0]    max_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the stack as a queue, back element is the top.
  logic [WIDTH-1:0] q[$];
  logic             exp_err;
  logic [1:0]       exp_code;
  int               exp_max;
  logic [WIDTH-1:0] pre_dout;

  lifo_stack_param #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
`ifdef LIFO_STACK_WATERMARK_EN
    , .AF_LEVEL(7)
`endif
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop),
    .data_in  (data_in),
    .data_out (data_out),
    .count    (count),
    .mem_full (mem_full),
    .mem_empty(mem_empty),
    .error    (error),
    .err_code (err_code)
`ifdef LIFO_STACK_WATERMARK_EN
    , .almost_full(almost_full),
    .max_count  (max_count)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "timeout");
  end

  function automatic logic [WIDTH-1:0] model_top();
    return (q.size() == 0) ? '0 : q[q.size()-1];
  endfunction

  task automatic model_reset();
    q.delete();
    exp_err  = 1'b0;
    exp_code = 2'b00;
    exp_max  = 0;
  endtask

  task automatic model_apply(input logic p, input logic o, input logic [WIDTH-1:0] d);
    exp_err = 1'b0;
    if (p && !o) begin
      if (q.size() == DEPTH) begin exp_err = 1'b1; exp_code = 2'b01; end
      else begin q.push_back(d); exp_code = 2'b00; end
    end else if (!p && o) begin
      if (q.size() == 0) begin exp_err = 1'b1; exp_code = 2'b10; end
      else begin void'(q.pop_back()); exp_code = 2'b00; end
    end else if (p && o) begin
      if (q.size() == 0) begin exp_err = 1'b1; exp_code = 2'b10; end
      else begin q[q.size()-1] = d; exp_code = 2'b00; end
    end
    if (q.size() > exp_max) exp_max = q.size();
  endtask

  // Drive one request for one clock; pre_dout captures the show-ahead value before the edge.
  task automatic step(input logic p, input logic o, input logic [WIDTH-1:0] d);
    @(negedge clock);
    push = p; pop = o; data_in = d;
    #1 pre_dout = data_out;
    model_apply(p, o, d);
    @(posedge clock);
    #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic do_reset(input logic p, input logic [WIDTH-1:0] d);
    @(negedge clock);
    reset_n = 1'b0; push = p; pop = 1'b0; data_in = d;
    @(posedge clock);
    #1;
    reset_n = 1'b1; push = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset(1'b0, '0);
    step(1'b0, 1'b0, '0);
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (mem_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", mem_empty); end
    n_checks++; if (mem_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", mem_full); end
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", data_out); end
    n_checks++; if (error !== 1'b0 || err_code !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b/%b want 0/00", error, err_code); end
    step(1'b0, 1'b1, '0);
    n_checks++; if (error !== 1'b1 || err_code !== 2'b10) begin n_fail++; $display("FAIL underflow_err: got %b/%b want 1/10", error, err_code); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL underflow_count: got %0d want 0", count); end
    step(1'b0, 1'b0, '0);
    n_checks++; if (error !== 1'b0 || err_code !== 2'b10) begin n_fail++; $display("FAIL err_pulse_hold: got %b/%b want 0/10", error, err_code); end
  endtask

  task automatic test_fill_overflow();
    logic [WIDTH-1:0] d;
    do_reset(1'b0, '0);
    for (int i = 1; i <= 8; i++) begin
      d = 8'(8'h11 * i);
      step(1'b1, 1'b0, d);
      n_checks++; if (data_out !== d || count !== 4'(i)) begin n_fail++; $display("FAIL fill_%0d: got dout %h cnt %0d want %h %0d", i, data_out, count, d, i); end
    end
    n_checks++; if (mem_full !== 1'b1 || mem_empty !== 1'b0) begin n_fail++; $display("FAIL fill_flags: got full %b empty %b want 1 0", mem_full, mem_empty); end
    step(1'b1, 1'b0, 8'h99);
    n_checks++; if (error !== 1'b1 || err_code !== 2'b01) begin n_fail++; $display("FAIL overflow_err: got %b/%b want 1/01", error, err_code); end
    n_checks++; if (data_out !== 8'h88 || count !== 4'd8) begin n_fail++; $display("FAIL overflow_state: got %h %0d want 88 8", data_out, count); end
  endtask

  task automatic test_drain();
    logic [WIDTH-1:0] d;
    for (int i = 8; i >= 1; i--) begin
      d = 8'(8'h11 * i);
      step(1'b0, 1'b1, '0);
      n_checks++; if (pre_dout !== d) begin n_fail++; $display("FAIL drain_showahead_%0d: got %h want %h", i, pre_dout, d); end
    end
    n_checks++; if (count !== 4'd0 || mem_empty !== 1'b1) begin n_fail++; $display("FAIL drain_end: got cnt %0d empty %b want 0 1", count, mem_empty); end
    n_checks++; if (err_code !== 2'b00 || error !== 1'b0) begin n_fail++; $display("FAIL drain_err: got %b/%b want 0/00", error, err_code); end
  endtask

  task automatic test_replace();
    do_reset(1'b0, '0);
    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b1, 8'hAB);
    n_checks++; if (count !== 4'd2 || data_out !== 8'hAB || error !== 1'b0) begin n_fail++; $display("FAIL replace: got cnt %0d dout %h err %b want 2 AB 0", count, data_out, error); end
    step(1'b0, 1'b1, '0);
    n_checks++; if (data_out !== 8'h11 || count !== 4'd1) begin n_fail++; $display("FAIL replace_pop: got %h %0d want 11 1", data_out, count); end
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 8'h5C);
    n_checks++; if (error !== 1'b1 || err_code !== 2'b10 || count !== 4'd0) begin n_fail++; $display("FAIL replace_empty: got %b/%b cnt %0d want 1/10 0", error, err_code, count); end
    // Replace on a full stack is legal.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(i));
    step(1'b1, 1'b1, 8'hEE);
    n_checks++; if (error !== 1'b0 || count !== 4'd8 || data_out !== 8'hEE) begin n_fail++; $display("FAIL replace_full: got err %b cnt %0d dout %h want 0 8 EE", error, count, data_out); end
  endtask

  task automatic test_reset_priority();
    do_reset(1'b0, '0);
    step(1'b1, 1'b0, 8'hA1);
    step(1'b1, 1'b0, 8'hA2);
    step(1'b1, 1'b0, 8'hA3);
    do_reset(1'b1, 8'h77);
    n_checks++; if (count !== 4'd0 || mem_empty !== 1'b1 || data_out !== 8'h00) begin n_fail++; $display("FAIL reset_prio: got cnt %0d empty %b dout %h want 0 1 00", count, mem_empty, data_out); end
    step(1'b1, 1'b0, 8'h5A);
    n_checks++; if (data_out !== 8'h5A || count !== 4'd1) begin n_fail++; $display("FAIL reset_then_push: got %h %0d want 5A 1", data_out, count); end
  endtask

  task automatic test_random();
    int r;
    do_reset(1'b0, '0);
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      step(1'b1, 1'b0, 8'($urandom));
      else if (r < 70) step(1'b0, 1'b1, 8'($urandom));
      else if (r < 85) step(1'b1, 1'b1, 8'($urandom));
      else if (r < 97) step(1'b0, 1'b0, 8'($urandom));
      else             do_reset(1'($urandom), 8'($urandom));
      n_checks++;
      if (count !== 4'(q.size()) || data_out !== model_top() || error !== exp_err || err_code !== exp_code ||
          mem_full !== (q.size() == DEPTH) || mem_empty !== (q.size() == 0)) begin
        n_fail++;
        $display("FAIL random_%0d: got cnt %0d dout %h err %b code %b full %b empty %b want %0d %h %b %b %b %b",
                 c, count, data_out, error, err_code, mem_full, mem_empty,
                 q.size(), model_top(), exp_err, exp_code, q.size() == DEPTH, q.size() == 0);
      end
`ifdef LIFO_STACK_WATERMARK_EN
      n_checks++;
      if (max_count !== 4'(exp_max) || almost_full !== (q.size() >= 7)) begin
        n_fail++;
        $display("FAIL random_wm_%0d: got max %0d af %b want %0d %b", c, max_count, almost_full, exp_max, q.size() >= 7);
      end
`endif
    end
  endtask

`ifdef LIFO_STACK_WATERMARK_EN
  task automatic test_watermark();
    do_reset(1'b0, '0);
    n_checks++; if (almost_full !== 1'b0 || max_count !== 4'd0) begin n_fail++; $display("FAIL wm_reset: got af %b max %0d want 0 0", almost_full, max_count); end
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(i + 1));
    n_checks++; if (almost_full !== 1'b1 || max_count !== 4'd7) begin n_fail++; $display("FAIL wm_push7: got af %b max %0d want 1 7", almost_full, max_count); end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);
    n_checks++; if (almost_full !== 1'b0 || max_count !== 4'd7) begin n_fail++; $display("FAIL wm_pop4: got af %b max %0d want 0 7", almost_full, max_count); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_fill_overflow();
    test_drain();
    test_replace();
    test_reset_priority();
`ifdef LIFO_STACK_WATERMARK_EN
    test_watermark();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
